// File: rtl/cci_mpf_if_pkg.sv
// Subset of the MPF/CCI interface types used by the memory responder:
// request/response type encodings, memory headers and channel structs.
`timescale 1ns/1ps
package cci_mpf_if_pkg;

    localparam int CCI_CLADDR_WIDTH = 42;
    localparam int CCI_CLDATA_WIDTH = 512;
    localparam int CCI_MDATA_WIDTH  = 16;

    typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;
    typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_clData;
    typedef logic [CCI_MDATA_WIDTH-1:0]  t_cci_mdata;

    typedef enum logic [3:0] {
        eREQ_RDLINE_S = 4'h0,
        eREQ_RDLINE_I = 4'h1,
        eREQ_WRLINE_I = 4'h2,
        eREQ_WRLINE_M = 4'h3,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_cci_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_WRLINE = 4'h1,
        eRSP_INTR   = 4'h6
    } t_cci_rsp;

    typedef struct packed {
        logic addrIsVirtual;
    } t_cci_mpf_ReqMemHdrExt;

    typedef struct packed {
        t_cci_mpf_ReqMemHdrExt ext;
        t_cci_req              req_type;
        t_cci_clAddr           address;
        t_cci_mdata            mdata;
    } t_cci_mpf_ReqMemHdr;

    typedef struct packed {
        t_cci_rsp   resp_type;
        t_cci_mdata mdata;
    } t_cci_RspMemHdr;

    typedef struct packed {
        t_cci_mpf_ReqMemHdr hdr;
        logic               rdValid;
    } t_if_cci_mpf_c0_Tx;

    typedef struct packed {
        t_cci_mpf_ReqMemHdr hdr;
        t_cci_clData        data;
        logic               wrValid;
    } t_if_cci_mpf_c1_Tx;

    typedef struct packed {
        t_cci_RspMemHdr hdr;
        t_cci_clData    data;
        logic           rdValid;
        logic           wrValid;
    } t_if_cci_c0_Rx;

    typedef struct packed {
        t_cci_RspMemHdr hdr;
        logic           wrValid;
    } t_if_cci_c1_Rx;

endpackage

// File: rtl/cci_mpf_mem_responder_pkg.sv
// Local types and constants for the MPF memory responder.
`timescale 1ns/1ps
package cci_mpf_mem_responder_pkg;

    localparam int MEM_RSP_ADDR_BITS = 10;

    typedef logic [MEM_RSP_ADDR_BITS-1:0] t_mem_rsp_line_idx;

    // Sticky error flags; bit 0 is overflow.
    typedef struct packed {
        logic addr_range;
        logic virt_addr;
        logic bad_type;
        logic overflow;
    } t_mem_rsp_err;

    localparam int ERR_OVERFLOW   = 0;
    localparam int ERR_BAD_TYPE   = 1;
    localparam int ERR_VIRT_ADDR  = 2;
    localparam int ERR_ADDR_RANGE = 3;

    localparam logic [15:0] MEM_RSP_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/cci_mpf_mem_rsp_fifo.sv
// Synchronous FIFO with occupancy count. Pushes while full and pops while
// empty are ignored; the caller detects overflow from the full flag.
`timescale 1ns/1ps
module cci_mpf_mem_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] data_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign dout      = data_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // Entry storage, not cleared by reset
    always_ff @(posedge clk) begin
        if (reset_n && push_ok_s) begin
            data_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/cci_mpf_mem_responder.sv
// Behavioural host-memory responder for an MPF CCI channel. Reads from c0Tx
// and writes/fences from c1Tx are queued, served from a local line memory
// and answered on c0Rx/c1Rx. Defining CCI_MPF_MEM_RSP_STALL_EN adds an LFSR
// that randomly stalls read-queue pops to emulate variable host latency.
`timescale 1ns/1ps
module cci_mpf_mem_responder
    import cci_mpf_if_pkg::*;
    import cci_mpf_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS      = MEM_RSP_ADDR_BITS,
    parameter int REQ_FIFO_DEPTH = 16,
    parameter int ALMFULL_SLACK  = 4,
    parameter int RD_LATENCY     = 4
)(
    input  logic              clk,
    input  logic              reset_n,
    input  t_if_cci_mpf_c0_Tx c0Tx,
    output logic              c0TxAlmFull,
    input  t_if_cci_mpf_c1_Tx c1Tx,
    output logic              c1TxAlmFull,
    output t_if_cci_c0_Rx     c0Rx,
    output t_if_cci_c1_Rx     c1Rx,
    input  logic              hold,
    output logic [3:0]        err_flags,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int CNT_W     = $clog2(REQ_FIFO_DEPTH) + 1;
    localparam int HDR_W     = $bits(t_cci_mpf_ReqMemHdr);
    localparam int WR_FIFO_W = HDR_W + CCI_CLDATA_WIDTH;
    localparam logic [CNT_W-1:0] ALMFULL_LEVEL = CNT_W'(REQ_FIFO_DEPTH - ALMFULL_SLACK);

    typedef logic [ADDR_BITS-1:0] t_line_idx;

    t_cci_clData          mem_r [2**ADDR_BITS];

    logic                 rd_push_s, rd_pop_s, rd_full_s, rd_empty_s, rd_stall_s;
    logic                 wr_push_s, wr_pop_s, wr_full_s, wr_empty_s;
    logic [CNT_W-1:0]     rd_occ_s, wr_occ_s, rd_occ_next_s, wr_occ_next_s;
    logic [HDR_W-1:0]     rd_fifo_dout_s;
    logic [WR_FIFO_W-1:0] wr_fifo_dout_s;
    t_cci_mpf_ReqMemHdr   rd_hdr_s, wr_hdr_s;
    t_cci_clData          wr_data_s, rd_data_s;
    t_line_idx            rd_idx_s, wr_idx_s;

    logic                 rd_issue_s, wr_write_s, wr_rsp_s;
    logic [3:0]           rd_err_s, wr_err_s, err_set_s;
    t_mem_rsp_err         err_r;

    t_if_cci_c0_Rx        rd_stage0_s;
    t_if_cci_c0_Rx        rd_pipe_next_s [RD_LATENCY];
    t_if_cci_c0_Rx        rd_pipe_r      [RD_LATENCY];
    t_if_cci_c1_Rx        c1_rx_next_s, c1_rx_r;
    logic [31:0]          rd_count_r, wr_count_r;
    logic                 c0_almfull_r, c1_almfull_r;

    assign rd_push_s = reset_n && c0Tx.rdValid;
    assign wr_push_s = reset_n && c1Tx.wrValid;

    cci_mpf_mem_rsp_fifo #(.WIDTH(HDR_W), .DEPTH(REQ_FIFO_DEPTH)) rd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rd_push_s),
        .din     (c0Tx.hdr),
        .pop     (rd_pop_s),
        .dout    (rd_fifo_dout_s),
        .full    (rd_full_s),
        .empty   (rd_empty_s),
        .count   (rd_occ_s)
    );

    cci_mpf_mem_rsp_fifo #(.WIDTH(WR_FIFO_W), .DEPTH(REQ_FIFO_DEPTH)) wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_push_s),
        .din     ({c1Tx.hdr, c1Tx.data}),
        .pop     (wr_pop_s),
        .dout    (wr_fifo_dout_s),
        .full    (wr_full_s),
        .empty   (wr_empty_s),
        .count   (wr_occ_s)
    );

    assign rd_hdr_s              = t_cci_mpf_ReqMemHdr'(rd_fifo_dout_s);
    assign {wr_hdr_s, wr_data_s} = wr_fifo_dout_s;
    assign rd_idx_s              = rd_hdr_s.address[ADDR_BITS-1:0];
    assign wr_idx_s              = wr_hdr_s.address[ADDR_BITS-1:0];

`ifdef CCI_MPF_MEM_RSP_STALL_EN
    logic [15:0] lfsr_r;

    // Free-running LFSR (taps 16,14,13,11) that picks read-stall cycles
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_r <= MEM_RSP_LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign rd_stall_s = (lfsr_r[1:0] == 2'b00);
`else
    assign rd_stall_s = 1'b0;
`endif

    assign rd_pop_s = reset_n && !rd_empty_s && !hold && !rd_stall_s;
    assign wr_pop_s = reset_n && !wr_empty_s && !hold;

    // Post-update occupancy feeding the registered almost-full flags
    assign rd_occ_next_s = rd_occ_s + CNT_W'(rd_push_s && !rd_full_s) - CNT_W'(rd_pop_s);
    assign wr_occ_next_s = wr_occ_s + CNT_W'(wr_push_s && !wr_full_s) - CNT_W'(wr_pop_s);

    // Classify the popped read request: serve, or drop and flag
    always_comb begin
        rd_err_s   = 4'b0000;
        rd_issue_s = 1'b0;
        if (rd_pop_s) begin
            if (rd_hdr_s.ext.addrIsVirtual) begin
                rd_err_s[ERR_VIRT_ADDR] = 1'b1;
            end else begin
                rd_err_s[ERR_ADDR_RANGE] = |rd_hdr_s.address[CCI_CLADDR_WIDTH-1:ADDR_BITS];
                case (rd_hdr_s.req_type)
                    eREQ_RDLINE_S, eREQ_RDLINE_I: rd_issue_s = 1'b1;
                    default:                      rd_err_s[ERR_BAD_TYPE] = 1'b1;
                endcase
            end
        end else begin
            rd_issue_s = 1'b0;
        end
    end

    // Classify the popped write request: write line, fence, or drop and flag
    always_comb begin
        wr_err_s   = 4'b0000;
        wr_write_s = 1'b0;
        wr_rsp_s   = 1'b0;
        if (wr_pop_s) begin
            if (wr_hdr_s.ext.addrIsVirtual) begin
                wr_err_s[ERR_VIRT_ADDR] = 1'b1;
            end else begin
                wr_err_s[ERR_ADDR_RANGE] = |wr_hdr_s.address[CCI_CLADDR_WIDTH-1:ADDR_BITS];
                case (wr_hdr_s.req_type)
                    eREQ_WRLINE_I, eREQ_WRLINE_M: begin
                        wr_write_s = 1'b1;
                        wr_rsp_s   = 1'b1;
                    end
                    eREQ_WRFENCE: wr_rsp_s = 1'b1;
                    default:      wr_err_s[ERR_BAD_TYPE] = 1'b1;
                endcase
            end
        end else begin
            wr_rsp_s = 1'b0;
        end
    end

    // Gather this cycle's new error events, including dropped pushes
    always_comb begin
        err_set_s = rd_err_s | wr_err_s;
        if (reset_n && ((c0Tx.rdValid && rd_full_s) || (c1Tx.wrValid && wr_full_s))) begin
            err_set_s[ERR_OVERFLOW] = 1'b1;
        end else begin
            err_set_s[ERR_OVERFLOW] = 1'b0;
        end
    end

    // Read data with write-first bypass for a same-cycle write to the same line
    always_comb begin
        if (wr_write_s && (wr_idx_s == rd_idx_s)) begin
            rd_data_s = wr_data_s;
        end else begin
            rd_data_s = mem_r[rd_idx_s];
        end
    end

    // Build the read response entering the latency pipeline and the shift
    always_comb begin
        rd_stage0_s = '0;
        if (rd_issue_s) begin
            rd_stage0_s.rdValid       = 1'b1;
            rd_stage0_s.hdr.resp_type = eRSP_RDLINE;
            rd_stage0_s.hdr.mdata     = rd_hdr_s.mdata;
            rd_stage0_s.data          = rd_data_s;
        end else begin
            rd_stage0_s.rdValid = 1'b0;
        end
        rd_pipe_next_s[0] = rd_stage0_s;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_next_s[i] = rd_pipe_r[i-1];
        end
    end

    // Build the write/fence response issued one cycle after the pop
    always_comb begin
        c1_rx_next_s = '0;
        if (wr_rsp_s) begin
            c1_rx_next_s.wrValid       = 1'b1;
            c1_rx_next_s.hdr.resp_type = eRSP_WRLINE;
            c1_rx_next_s.hdr.mdata     = wr_hdr_s.mdata;
        end else begin
            c1_rx_next_s.wrValid = 1'b0;
        end
    end

    // Line memory write at the write pop; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_write_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Response pipelines, counters, sticky errors and flow control
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_pipe_r[i] <= '0;
            end
            c1_rx_r      <= '0;
            rd_count_r   <= 32'd0;
            wr_count_r   <= 32'd0;
            err_r        <= '0;
            c0_almfull_r <= 1'b1;
            c1_almfull_r <= 1'b1;
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_pipe_r[i] <= rd_pipe_next_s[i];
            end
            c1_rx_r      <= c1_rx_next_s;
            rd_count_r   <= rd_count_r + {31'd0, rd_pipe_next_s[RD_LATENCY-1].rdValid};
            wr_count_r   <= wr_count_r + {31'd0, c1_rx_next_s.wrValid};
            err_r        <= err_r | t_mem_rsp_err'(err_set_s);
            c0_almfull_r <= (rd_occ_next_s >= ALMFULL_LEVEL);
            c1_almfull_r <= (wr_occ_next_s >= ALMFULL_LEVEL);
        end
    end

    assign c0Rx        = rd_pipe_r[RD_LATENCY-1];
    assign c1Rx        = c1_rx_r;
    assign c0TxAlmFull = c0_almfull_r;
    assign c1TxAlmFull = c1_almfull_r;
    assign err_flags   = err_r;
    assign rd_count    = rd_count_r;
    assign wr_count    = wr_count_r;

endmodule

// File: doc/cci_mpf_mem_responder.md
Name: cci_mpf_mem_responder

Overview:
- Responder end of the MPF CCI request/response protocol: a behavioural host-memory model on the platform side of an MPF channel.
- Accepts AFU read requests on c0Tx and write/fence requests on c1Tx, services them from a local line memory, and returns responses on c0Rx/c1Rx.
- Drives c0TxAlmFull/c1TxAlmFull flow control.
- Used in simulation and in on-FPGA loopback tests in place of the real QLP.

Parameters:
- ADDR_BITS, 10: line-index width; memory holds 2^ADDR_BITS 512-bit lines.
- REQ_FIFO_DEPTH, 16: entries per request FIFO (read and write); power of 2.
- ALMFULL_SLACK, 4: almost-full asserts when occupancy >= REQ_FIFO_DEPTH - ALMFULL_SLACK.
- RD_LATENCY, 4: cycles from read-FIFO pop to c0Rx.rdValid; >= 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- c0Tx  in  t_if_cci_mpf_c0_Tx  read requests (rdValid, hdr)
- c0TxAlmFull  out  1  read-request flow control
- c1Tx  in  t_if_cci_mpf_c1_Tx  write/fence requests (wrValid, hdr, data)
- c1TxAlmFull  out  1  write-request flow control
- c0Rx  out  t_if_cci_c0_Rx  read responses
- c1Rx  out  t_if_cci_c1_Rx  write/fence responses
- hold  in  1  test back-pressure; while 1, no FIFO pops
- err_flags  out  4  sticky: [0] overflow, [1] bad req_type, [2] virtual address, [3] address out of range
- rd_count  out  32  read responses issued
- wr_count  out  32  write/fence responses issued

Behaviour:
- Reset (reset_n=0 at posedge):
  - FIFOs, read pipeline, counters and err_flags cleared.
  - All Rx valids 0, all Rx fields 0.
  - AlmFull outputs 1 while in reset; they take the occupancy value from the first cycle after reset.
  - Memory contents are not cleared.
  - Reset mid-operation discards in-flight requests with no responses.
- Request acceptance, sampled at posedge with reset_n=1:
  - c0Tx.rdValid pushes hdr into the read FIFO.
  - c1Tx.wrValid pushes hdr+data into the write FIFO.
  - Push while FIFO full: request dropped, err_flags[0] set.
- AlmFull: registered, computed from post-update occupancy, so it is valid the cycle after the push or pop that changed it.
- Request checks at pop:
  - hdr.ext.addrIsVirtual=1: dropped, no response, err_flags[2] set.
  - address bits above ADDR_BITS nonzero: err_flags[3] set; request still served using the low bits (wrap).
- Read path:
  - Pops one entry per cycle when non-empty and hold=0.
  - Legal req_type: eREQ_RDLINE_S or eREQ_RDLINE_I. Others are dropped and set err_flags[1].
  - Memory is read at the pop cycle.
  - Result goes through a RD_LATENCY-stage valid/mdata/data shift register. c0Rx.rdValid=1, hdr.resp_type=eRSP_RDLINE, hdr.mdata=request mdata, data=line. Exactly RD_LATENCY cycles after the pop.
  - At most one response per cycle; responses stay in request order.
  - c0Rx.wrValid is always 0.
- Write path:
  - Pops one entry per cycle when non-empty and hold=0.
  - eREQ_WRLINE_I / eREQ_WRLINE_M: memory[addr] <= data at the pop cycle.
  - eREQ_WRFENCE: no memory write. Because writes retire in order, the fence completes at its pop.
  - Any other type: dropped, err_flags[1] set.
  - Response: c1Rx.wrValid=1 the cycle after the pop, resp_type=eRSP_WRLINE, mdata echoed.
- Same-cycle read and write pop to the same index: the read returns the new write data (write-first bypass).
- Counters: 32-bit wrap-around, increment on each issued response.
- hold: freezes pops only. Pushes continue and in-flight pipeline stages still drain.

Optional Feature:
- Macro: CCI_MPF_MEM_RSP_STALL_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on reset, advances every cycle.
  - Read-FIFO pop is suppressed on cycles where lfsr[1:0]==2'b00.
  - Models variable host latency; ordering and data behaviour are unchanged.
- Undefined: no LFSR; pops are gated only by empty and hold.

Decomposition:
- Package cci_mpf_mem_responder_pkg holds:
  - t_mem_rsp_line_idx (ADDR_BITS wide)
  - t_mem_rsp_err (4-bit struct)
  - error-bit index constants
  - LFSR seed constant
- Request type encodings and header structs come from the existing MPF/CCI packages.
- Sub-module: cci_mpf_mem_rsp_fifo, a parameterised synchronous FIFO with count output. It is instantiated twice: hdr-only for reads, hdr+data for writes.

Test Plan:
- Write-then-read, to observe latency and data:
  - Stimulus: WRLINE_I addr 0x5, data 512'hDEADBEEF, mdata 0x21; then RDLINE_S addr 0x5, mdata 0x12.
  - Response: c1Rx.wrValid with mdata 0x21 one cycle after pop; c0Rx.rdValid with mdata 0x12 and data DEADBEEF exactly 4 cycles after read pop; rd_count=1, wr_count=1.
- Almost-full:
  - Stimulus: hold=1, push 12 reads.
  - Response: c0TxAlmFull=1 the cycle after the 12th push. Release hold: it deasserts after occupancy drops to 11, and all 12 responses return in mdata order.
- Overflow: hold=1, push 17 reads -> err_flags[0]=1; exactly 16 responses after hold release.
- Fence and bad type: WRFENCE mdata 0x7 -> eRSP_WRLINE with mdata 0x7 and no memory change; eREQ_INTR on c1 -> no response, err_flags[1]=1.
- Same-cycle bypass: read and write pop to addr 0x3 in the same cycle with data 0xA5 -> read returns 0xA5.
- Reset mid-operation: 3 reads in flight, reset_n=0 for 1 cycle -> no rdValid afterward; AlmFull=1 during reset; memory[0x5] still holds DEADBEEF.
